sram_burst_master: RTL and testbench
====================================

SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, the SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the SRAM word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, the burst length field width.
REQ-004 SHALL have one clock and an asynchronous active-high reset: i_clk  in  1  clock, all state on rising edge; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_cmd_valid  in  1  command offered.
REQ-006 SHALL have o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
REQ-007 SHALL have i_cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have i_cmd_addr  in  ADDR_WIDTH  burst start address.
REQ-009 SHALL have i_cmd_len  in  LEN_WIDTH  beats minus one.
REQ-010 SHALL have i_wdata_valid / o_wdata_ready  in/out  1  write-data handshake.
REQ-011 SHALL have i_wdata  in  DATA_WIDTH  write beat.
REQ-012 SHALL have o_rdata_valid / i_rdata_ready  out/in  1  read-data handshake.
REQ-013 SHALL have o_rdata  out  DATA_WIDTH  read beat; o_rdata_last  out  1  final beat of burst.
REQ-014 SHALL have o_busy  out  1  burst in progress or read data outstanding.
REQ-015 SHALL have o_sram_addr  out  ADDR_WIDTH, o_sram_write  out  1, o_sram_data  out  DATA_WIDTH  drive the single-port SRAM.
REQ-016 SHALL have i_sram_data  in  DATA_WIDTH  SRAM registered read output.

Function
REQ-017 SHALL implement FSM IDLE, WRITE, READ; o_cmd_ready = 1 only in IDLE.
REQ-018 SHALL, on command handshake, latch addr, len+1 beat count, last flag, and go to WRITE or READ next cycle.
REQ-019 SHALL, in WRITE, set o_wdata_ready = 1 and, in any cycle with i_wdata_valid high, drive o_sram_write = 1, o_sram_addr = current addr, o_sram_data = i_wdata combinationally.
REQ-020 SHALL, in READ, issue one read per cycle (o_sram_write = 0, o_sram_addr = current addr) only when buffer occupancy + in-flight reads - this cycle's pop < 2.
REQ-021 SHALL treat SRAM read latency as exactly 1 cycle: data for a read issued in cycle t is captured from i_sram_data at the end of cycle t+1 into a 2-entry response FIFO.
REQ-022 SHALL present FIFO head on o_rdata/o_rdata_valid, pop on o_rdata_valid & i_rdata_ready, and tag only the burst's final beat with o_rdata_last.
REQ-023 SHALL increment address after each issued beat modulo 2^ADDR_WIDTH (0xF -> 0x0 at default).
REQ-024 SHALL return to IDLE in the cycle after the final beat is issued; a new command MAY be accepted while the last read data is still buffered.
REQ-025 SHALL keep o_sram_write = 0 in IDLE and READ, and whenever WRITE has no valid beat.
REQ-026 SHALL assert o_busy when state != IDLE, a read is in flight, or FIFO non-empty.
REQ-027 SHALL sustain one beat per cycle for both directions when upstream/downstream never stall.

Reset
REQ-028 SHALL, on i_rst, asynchronously force IDLE, empty FIFO, drop any in-flight read, and zero o_sram_addr, o_sram_data, o_sram_write, o_rdata, o_rdata_valid, o_rdata_last, o_wdata_ready, o_busy; o_cmd_ready = 1 after reset release.
REQ-029 SHALL tolerate reset mid-burst: no SRAM write occurs after assertion, and no stale beat appears after release.

Structure
REQ-030 SHALL place FSM state encoding and the FIFO depth constant (2) in shared package sram_pkg.
REQ-031 SHALL implement the response buffer as sub-module sram_resp_fifo (2 entries, data + last bit).

Verification
REQ-032 SHALL cover write burst addr 0x3 len 3, data 0xA0..0xA3 -> SRAM writes to 0x3..0x6 on 4 consecutive cycles.
REQ-033 SHALL cover read burst addr 0x3 len 3, i_rdata_ready = 1 -> 0xA0..0xA3 on 4 consecutive cycles, last on 0xA3.
REQ-034 SHALL cover read with i_rdata_ready low 5 cycles -> at most 2 reads outstanding, no beat lost or duplicated, order preserved.
REQ-035 SHALL cover write burst addr 0xE len 2 -> writes to 0xE, 0xF, 0x0.
REQ-036 SHALL cover i_wdata_valid gaps during write -> o_sram_write low in gap cycles, address unchanged.
REQ-037 SHALL cover i_rst during read beat 2 of 4 -> outputs zero immediately, o_rdata_valid stays low after release until a new command.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst master: FSM encoding and the
// response FIFO geometry.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Small response buffer for SRAM read data; each entry carries the data word
// and the burst-final flag.
module sram_resp_fifo
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic                  last_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    // NOTE: storage is left unreset; the pointers and count define what is
    // valid, and the head is masked while empty so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

    assign valid = (count != '0);
    assign data  = valid ? data_mem[rd_ptr] : '0;
    assign last  = valid & last_mem[rd_ptr];

endmodule

// File: rtl/sram_burst_master.sv
// Burst master for a single-port SRAM with a 1-cycle registered read port:
// accepts write/read burst commands and streams beats at one per cycle.
module sram_burst_master
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rdata_last,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    input  logic [DATA_WIDTH-1:0] i_sram_data
);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH:0]     beats_left;
    logic                   rd_inflight;
    logic                   rd_inflight_last;

    logic                   fifo_valid;
    logic [DATA_WIDTH-1:0]  fifo_data;
    logic                   fifo_last;
    logic [FIFO_CNT_W-1:0]  fifo_count;

    logic                   write_fire;
    logic                   issue;
    logic                   pop;
    logic                   final_beat;
    logic [FIFO_CNT_W:0]    committed;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        write_fire = 1'b0;
        issue      = 1'b0;
        pop        = fifo_valid & i_rdata_ready;
        final_beat = (beats_left == (LEN_WIDTH+1)'(1));
        // Entries buffered plus reads in flight, after this cycle's pop.
        committed  = {1'b0, fifo_count} + (FIFO_CNT_W+1)'(rd_inflight)
                   - (FIFO_CNT_W+1)'(pop);
        if (state == ST_WRITE) begin
            write_fire = i_wdata_valid;
        end
        if (state == ST_READ) begin
            issue = (committed < (FIFO_CNT_W+1)'(FIFO_DEPTH));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            addr             <= '0;
            beats_left       <= '0;
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            rd_inflight      <= issue;
            rd_inflight_last <= issue & final_beat;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        addr       <= i_cmd_addr;
                        beats_left <= {1'b0, i_cmd_len} + (LEN_WIDTH+1)'(1);
                        state      <= i_cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (write_fire || issue) begin
                        addr       <= addr + ADDR_WIDTH'(1);
                        beats_left <= beats_left - (LEN_WIDTH+1)'(1);
                        if (final_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data is captured the cycle after issue, tagged with its last flag.
    sram_resp_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (rd_inflight),
        .push_data (i_sram_data),
        .push_last (rd_inflight_last),
        .pop       (pop),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .last      (fifo_last),
        .count     (fifo_count)
    );

    assign o_cmd_ready   = (state == ST_IDLE) & ~i_rst;
    assign o_wdata_ready = (state == ST_WRITE);
    assign o_sram_write  = write_fire;
    assign o_sram_addr   = (state == ST_IDLE) ? '0 : addr;
    assign o_sram_data   = write_fire ? i_wdata : '0;
    assign o_rdata_valid = fifo_valid;
    assign o_rdata       = fifo_data;
    assign o_rdata_last  = fifo_last;
    assign o_busy        = (state != ST_IDLE) | rd_inflight | fifo_valid;

endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master: behavioural SRAM, reference
// memory image and expected-beat queues built from burst rules.
module tb_sram_burst_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [LW-1:0] i_cmd_len;
    logic          i_wdata_valid;
    logic          o_wdata_ready;
    logic [DW-1:0] i_wdata;
    logic          o_rdata_valid;
    logic          i_rdata_ready;
    logic [DW-1:0] o_rdata;
    logic          o_rdata_last;
    logic          o_busy;
    logic [AW-1:0] o_sram_addr;
    logic          o_sram_write;
    logic [DW-1:0] o_sram_data;
    logic [DW-1:0] i_sram_data;

    logic [DW-1:0] sram_mem [16];
    logic [DW-1:0] ref_mem  [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_burst_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_len     (i_cmd_len),
        .i_wdata_valid (i_wdata_valid),
        .o_wdata_ready (o_wdata_ready),
        .i_wdata       (i_wdata),
        .o_rdata_valid (o_rdata_valid),
        .i_rdata_ready (i_rdata_ready),
        .o_rdata       (o_rdata),
        .o_rdata_last  (o_rdata_last),
        .o_busy        (o_busy),
        .o_sram_addr   (o_sram_addr),
        .o_sram_write  (o_sram_write),
        .o_sram_data   (o_sram_data),
        .i_sram_data   (i_sram_data)
    );

    // Single-port SRAM with a registered read port (1-cycle latency).
    always @(posedge clk) begin
        i_sram_data <= sram_mem[o_sram_addr];
        if (o_sram_write) begin
            sram_mem[o_sram_addr] <= o_sram_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input int len);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_write = w;
        i_cmd_addr  = a;
        i_cmd_len   = LW'(len);
        #1;
        check("cmd_ready", o_cmd_ready, 1);
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    // Write burst; gap_pct is the chance of an idle wdata cycle.
    task automatic do_write(input logic [AW-1:0] a, input int len, input int gap_pct,
                            input logic [DW-1:0] base, input bit rnd);
        logic [AW-1:0] cur;
        logic [DW-1:0] d;
        logic          v;
        int            i;
        int            cycles;
        send_cmd(1'b1, a, len);
        cur    = a;
        i      = 0;
        cycles = 0;
        while (i <= len && cycles < 200) begin
            @(negedge clk);
            v = (int'($urandom_range(99)) >= gap_pct);
            d = rnd ? DW'($urandom) : base + DW'(i);
            i_wdata_valid = v;
            i_wdata       = d;
            #1;
            check("wr_ready", o_wdata_ready, 1);
            check("wr_we", o_sram_write, v);
            check("wr_addr", o_sram_addr, cur);
            if (v) check("wr_data", o_sram_data, d);
            @(posedge clk);
            if (v) begin
                ref_mem[cur] = d;
                cur = cur + 1'b1;
                i++;
            end
            cycles++;
        end
        if (i <= len) check("wr_timeout", 0, 1);
        @(negedge clk);
        i_wdata_valid = 1'b0;
        #1;
        check("wr_done_cmd_ready", o_cmd_ready, 1);
        check("wr_done_wready", o_wdata_ready, 0);
        check("wr_done_we", o_sram_write, 0);
    endtask

    // Read burst; mode 0 = always ready, 1 = ready low for 5 cycles, 2 = random.
    task automatic do_read(input logic [AW-1:0] a, input int len, input int mode);
        logic [DW-1:0] exp_d[$];
        logic          exp_l[$];
        logic [AW-1:0] ak;
        logic          r;
        logic          fire;
        int            cycles;
        int            first_c;
        int            last_c;
        for (int k = 0; k <= len; k++) begin
            ak = a + AW'(k);
            exp_d.push_back(ref_mem[ak]);
            exp_l.push_back(k == len);
        end
        send_cmd(1'b0, a, len);
        cycles  = 0;
        first_c = -1;
        last_c  = -1;
        while (exp_d.size() > 0 && cycles < 300) begin
            @(negedge clk);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles >= 5);
                default: r = $urandom_range(1) == 1;
            endcase
            i_rdata_ready = r;
            #1;
            check("rd_we", o_sram_write, 0);
            check("rd_busy", o_busy, 1);
            fire = o_rdata_valid & r;
            if (o_rdata_valid) begin
                check("rd_data", o_rdata, exp_d[0]);
                check("rd_last", o_rdata_last, exp_l[0]);
            end
            @(posedge clk);
            if (fire) begin
                if (first_c < 0) first_c = cycles;
                last_c = cycles;
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
            cycles++;
        end
        if (exp_d.size() > 0) check("rd_timeout", 0, 1);
        if (mode == 0) begin
            check("rd_latency", first_c, 2);
            check("rd_back_to_back", last_c - first_c, len);
        end
        @(negedge clk);
        i_rdata_ready = 1'b0;
        #1;
        check("rd_done_valid", o_rdata_valid, 0);
        check("rd_done_busy", o_busy, 0);
        check("rd_done_cmd_ready", o_cmd_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sram_addr"}, o_sram_addr, 0);
        check({tag, "_sram_write"}, o_sram_write, 0);
        check({tag, "_sram_data"}, o_sram_data, 0);
        check({tag, "_rdata"}, o_rdata, 0);
        check({tag, "_rdata_valid"}, o_rdata_valid, 0);
        check({tag, "_rdata_last"}, o_rdata_last, 0);
        check({tag, "_wdata_ready"}, o_wdata_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        i_cmd_valid   = 1'b0;
        i_cmd_write   = 1'b0;
        i_cmd_addr    = '0;
        i_cmd_len     = '0;
        i_wdata_valid = 1'b0;
        i_wdata       = '0;
        i_rdata_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sram_mem[k] = '0;
            ref_mem[k]  = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_cmd_ready", o_cmd_ready, 1);
        check("reset_busy", o_busy, 0);

        // Fill the whole SRAM with known random content
        do_write(4'h0, 15, 0, '0, 1'b1);

        // Back-to-back write and read of 0xA0..0xA3 at 0x3
        do_write(4'h3, 3, 0, 32'hA0, 1'b0);
        do_read(4'h3, 3, 0);

        // Downstream stalled for 5 cycles
        do_read(4'h3, 3, 1);

        // Address wrap 0xE -> 0xF -> 0x0
        do_write(4'hE, 2, 0, 32'hB0, 1'b0);
        do_read(4'hD, 4, 0);

        // Write-data gaps
        do_write(4'h5, 5, 40, '0, 1'b1);
        do_read(4'h4, 7, 2);

        // Reset in the middle of a write burst
        send_cmd(1'b1, 4'h8, 7);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_wdata_valid = 1'b1;
            i_wdata       = 32'hC0 + DW'(k);
            @(posedge clk);
            ref_mem[AW'(8 + k)] = 32'hC0 + DW'(k);
        end
        @(negedge clk);
        i_wdata = 32'hDEAD_BEEF;
        #1;
        check("rstw_we_before", o_sram_write, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rstw");
        @(posedge clk);
        @(negedge clk);
        i_wdata_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_cmd_ready", o_cmd_ready, 1);
        do_read(4'h8, 7, 0);

        // Reset while the second of four read beats is being issued
        send_cmd(1'b0, 4'h3, 3);
        @(negedge clk);
        i_rdata_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rstr");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check("rstr_no_stale", o_rdata_valid, 0);
            check("rstr_idle_busy", o_busy, 0);
        end
        i_rdata_ready = 1'b0;
        do_read(4'h3, 3, 0);

        // Randomized bursts against the reference image
        for (int n = 0; n < 8; n++) begin
            do_write(AW'($urandom_range(15)), int'($urandom_range(15)), 30, '0, 1'b1);
            do_read(AW'($urandom_range(15)), int'($urandom_range(15)), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
